// File: rtl/decode_stage_if.sv
// Fetch -> decode -> rename bundle interface.
// The master drives the fetch bundle, the flush and rename_rdy.
// The slave is the decode stage, which returns decoder_rdy and the decoded pair.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            flush;
  logic            inst_val;
  logic            decoder_rdy;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_4;
  logic [XLEN-1:0] inst0;
  logic [XLEN-1:0] inst1;

  // rename side
  logic            dec_val;
  logic            rename_rdy;
  logic [XLEN-1:0] dec_pc0;
  logic [XLEN-1:0] dec_pc1;
  logic [3:0]      dec_cls0;
  logic [3:0]      dec_cls1;
  logic [14:0]     dec_regs0;
  logic [14:0]     dec_regs1;
  logic [XLEN-1:0] dec_imm0;
  logic [XLEN-1:0] dec_imm1;
  logic [3:0]      dec_fn0;
  logic [3:0]      dec_fn1;
  logic [2:0]      dec_flags0;
  logic [2:0]      dec_flags1;

  modport master (
    output flush, inst_val, pc, pc_4, inst0, inst1, rename_rdy,
    input  decoder_rdy, dec_val, dec_pc0, dec_pc1, dec_cls0, dec_cls1,
           dec_regs0, dec_regs1, dec_imm0, dec_imm1, dec_fn0, dec_fn1,
           dec_flags0, dec_flags1
  );

  modport slave (
    input  flush, inst_val, pc, pc_4, inst0, inst1, rename_rdy,
    output decoder_rdy, dec_val, dec_pc0, dec_pc1, dec_cls0, dec_cls1,
           dec_regs0, dec_regs1, dec_imm0, dec_imm1, dec_fn0, dec_fn1,
           dec_flags0, dec_flags1
  );
endinterface

// File: rtl/decode_stage.sv
// Two-wide RV32I decode stage with an output register (R) and a skid
// register (S). Both registers hold fully decoded fields.
//
// Handshake: a bundle moves from fetch when inst_val && decoder_rdy && !flush,
// and a pair moves to rename when dec_val && rename_rdy && !flush. decoder_rdy
// is !S_valid only, so it never depends combinationally on rename_rdy. Once
// dec_val is high, every dec_* output holds until rename takes the pair.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_stage_if.slave     bus,
  output logic [1:0]        dbg_valid   // {S_valid, R_valid}
);

  localparam logic [3:0] CLS_R_ALU  = 4'd0;
  localparam logic [3:0] CLS_I_ALU  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_SYS    = 4'd9;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [14:0]     regs;   // {rd, rs1, rs2}
    logic [XLEN-1:0] imm;
    logic [3:0]      fn;     // {inst[30], funct3}
    logic [2:0]      flags;  // {writes_rd, uses_rs2, uses_rs1}
  } slot_t;

  typedef struct packed {
    slot_t s0;
    slot_t s1;
  } bundle_t;

  // Decode one raw word into its slot fields.
  function automatic slot_t decode_slot(input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] inst);
    slot_t       s;
    logic [31:0] w;
    logic [31:0] imm32;
    logic        wr;
    logic        u2;
    logic        u1;
    w      = inst[31:0];
    s.pc   = a;
    s.regs = {w[11:7], w[19:15], w[24:20]};
    s.fn   = {w[30], w[14:12]};
    s.cls  = CLS_ILL;
    imm32  = '0;
    wr     = 1'b0;
    u2     = 1'b0;
    u1     = 1'b0;
    if (w[1:0] == 2'b11) begin
      case (w[6:2])
        5'b01100: begin s.cls = CLS_R_ALU; wr = 1'b1; u2 = 1'b1; u1 = 1'b1; end
        5'b00100: begin s.cls = CLS_I_ALU; wr = 1'b1; u1 = 1'b1;
                        imm32 = {{20{w[31]}}, w[31:20]}; end
        5'b00000: begin s.cls = CLS_LOAD; wr = 1'b1; u1 = 1'b1;
                        imm32 = {{20{w[31]}}, w[31:20]}; end
        5'b01000: begin s.cls = CLS_STORE; u2 = 1'b1; u1 = 1'b1;
                        imm32 = {{20{w[31]}}, w[31:25], w[11:7]}; end
        5'b11000: begin s.cls = CLS_BRANCH; u2 = 1'b1; u1 = 1'b1;
                        imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
        5'b11011: begin s.cls = CLS_JAL; wr = 1'b1;
                        imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
        5'b11001: begin s.cls = CLS_JALR; wr = 1'b1; u1 = 1'b1;
                        imm32 = {{20{w[31]}}, w[31:20]}; end
        5'b01101: begin s.cls = CLS_LUI; wr = 1'b1; imm32 = {w[31:12], 12'h000}; end
        5'b00101: begin s.cls = CLS_AUIPC; wr = 1'b1; imm32 = {w[31:12], 12'h000}; end
        5'b00011,
        5'b11100: begin s.cls = CLS_SYS; imm32 = {{20{w[31]}}, w[31:20]}; end
        default:  ;
      endcase
    end
    s.imm   = XLEN'($signed(imm32));
    // A write to x0 is architecturally a no-op, so rename never sees it.
    s.flags = {wr && (w[11:7] != 5'd0), u2, u1};
    return s;
  endfunction

  bundle_t r_data;
  bundle_t s_data;
  bundle_t new_data;
  logic    r_valid;
  logic    s_valid;
  logic    accept;
  logic    xfer;
  logic    r_load_new;
  logic    r_load_skid;
  logic    s_load;

  // Decode the offered bundle and work out where it lands this cycle.
  always_comb begin
    new_data.s0 = decode_slot(bus.pc, bus.inst0);
    new_data.s1 = decode_slot(bus.pc_4, bus.inst1);
    accept      = bus.inst_val && !s_valid && !bus.flush;
    xfer        = r_valid && bus.rename_rdy;
    r_load_skid = xfer && s_valid;
    r_load_new  = accept && (!r_valid || (xfer && !s_valid));
    s_load      = accept && !r_load_new;
  end

  // Output/skid register pair; flush empties both ahead of any other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      s_valid <= 1'b0;
      r_data  <= '0;
      s_data  <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      if (r_load_skid) r_data <= s_data;
      else if (r_load_new) r_data <= new_data;
      if (s_load) s_data <= new_data;
      r_valid <= r_load_new || r_load_skid || (r_valid && !xfer);
      s_valid <= s_load || (s_valid && !r_load_skid);
    end
  end

  assign bus.decoder_rdy = !s_valid;
  assign bus.dec_val     = r_valid;
  assign bus.dec_pc0     = r_data.s0.pc;
  assign bus.dec_cls0    = r_data.s0.cls;
  assign bus.dec_regs0   = r_data.s0.regs;
  assign bus.dec_imm0    = r_data.s0.imm;
  assign bus.dec_fn0     = r_data.s0.fn;
  assign bus.dec_flags0  = r_data.s0.flags;
  assign bus.dec_pc1     = r_data.s1.pc;
  assign bus.dec_cls1    = r_data.s1.cls;
  assign bus.dec_regs1   = r_data.s1.regs;
  assign bus.dec_imm1    = r_data.s1.imm;
  assign bus.dec_fn1     = r_data.s1.fn;
  assign bus.dec_flags1  = r_data.s1.flags;
  assign dbg_valid       = {s_valid, r_valid};

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the address and instruction width of every data port.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 flush  input  1  SHALL be the synchronous pipeline kill from the ROB.
REQ-005 inst_val  input  1  SHALL mark the fetch bundle as valid.
REQ-006 decoder_rdy  output  1  SHALL mean decode can accept a bundle this cycle.
REQ-007 pc, pc_4  input  XLEN each  SHALL give the addresses of inst0 and inst1.
REQ-008 inst0, inst1  input  XLEN each  SHALL carry the raw RV32I words; inst0 is older.
REQ-009 dec_val  output  1  SHALL mark the decoded pair as valid to rename.
REQ-010 rename_rdy  input  1  SHALL mean rename consumes the pair this cycle.
REQ-011 dec_pc0, dec_pc1  output  XLEN each  SHALL carry the slot PCs.
REQ-012 dec_cls0, dec_cls1  output  4 each  SHALL carry the op class: 0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM/FENCE, 15 ILLEGAL.
REQ-013 dec_regs0, dec_regs1  output  15 each  SHALL carry {rd, rs1, rs2}.
REQ-014 dec_imm0, dec_imm1  output  XLEN each  SHALL carry the sign-extended immediate.
REQ-015 dec_fn0, dec_fn1  output  4 each  SHALL carry {inst[30], funct3}.
REQ-016 dec_flags0, dec_flags1  output  3 each  SHALL carry {writes_rd, uses_rs2, uses_rs1}.

Function
REQ-017 A bundle SHALL be accepted when inst_val && decoder_rdy && !flush.
REQ-018 A pair SHALL transfer to rename when dec_val && rename_rdy.
REQ-019 Storage SHALL be one output register R (drives the dec_* outputs) and one skid register S.
REQ-020 decoder_rdy SHALL equal !S_valid and SHALL be combinationally independent of rename_rdy.
REQ-021 An accepted bundle SHALL go to R if R is empty, or is being consumed with S empty; otherwise it SHALL go to S.
REQ-022 When R is consumed and S is valid, S SHALL move to R, and any bundle accepted that cycle SHALL go to S.
REQ-023 Latency from accept to dec_val SHALL be exactly 1 cycle.
REQ-024 Throughput SHALL be 1 bundle per cycle while rename_rdy=1.
REQ-025 Bundles SHALL never be dropped, duplicated or reordered, except by flush.
REQ-026 While dec_val=1 and rename_rdy=0, every dec_* output SHALL hold stable.
REQ-027 Decode SHALL be performed before registering, so R and S hold decoded fields only.
REQ-028 Immediate formats SHALL be:
- I: sext(inst[31:20]).
- S: sext({inst[31:25], inst[11:7]}).
- B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- U: {inst[31:12], 12'h0}.
- J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- R: 0.
REQ-029 uses_rs1 SHALL be 1 for R-ALU, I-ALU, LOAD, STORE, BRANCH and JALR.
REQ-030 uses_rs2 SHALL be 1 for R-ALU, STORE and BRANCH.
REQ-031 writes_rd SHALL be 1 for every class except STORE, BRANCH, SYSTEM/FENCE and ILLEGAL.
REQ-032 writes_rd SHALL be forced to 0 when rd=x0.
REQ-033 A word with inst[1:0]!=2'b11 or an unknown opcode SHALL decode as class 15 with flags 0 and imm 0; its regs and fn fields are don't-care.
REQ-034 dec_pc1 SHALL equal pc_4 as registered, not recomputed.
REQ-035 flush SHALL have priority over all events: next cycle R_valid=S_valid=0, and any bundle offered that cycle is discarded.
REQ-036 A flush coinciding with rename_rdy=1 SHALL count as neither a transfer nor an accept.

Reset
REQ-037 While rst=0, R_valid and S_valid SHALL be 0, so dec_val=0 and decoder_rdy=1.
REQ-038 While rst=0, all R/S data fields SHALL be 0.
REQ-039 Reset deassertion mid-handshake SHALL lose any in-flight bundle; the first accept SHALL be possible on the first rising edge after rst=1.

Verification
REQ-040 Single bundle: pc=0x100, inst0=0x00500093 (addi x1,x0,5), inst1=0x002081B3 (add x3,x1,x2), rename_rdy=1 -> next cycle dec_val=1.
- Slot 0: cls=1, regs={1,0,-}, imm=5, flags=3'b101.
- Slot 1: cls=0, regs={3,1,2}, flags=3'b111, dec_pc1=0x104.
REQ-041 Backpressure: 3 back-to-back bundles with rename_rdy=0 -> decoder_rdy=0 after the 2nd accept; 3rd held by fetch; rename_rdy=1 then releases all 3 in order, one per cycle.
REQ-042 Immediates:
- inst0=0xFE000EE3 (beq x0,x0,-4) -> cls 4, imm=0xFFFFFFFC.
- inst0=0x0000006F (jal x0,0) -> cls 5, writes_rd=0.
REQ-043 Illegal: inst0=0x00000000 -> cls 15, flags 0, imm 0, dec_val still 1.
REQ-044 Flush with R and S both full plus inst_val=1 -> next cycle dec_val=0, decoder_rdy=1, no stale pair ever emitted.
REQ-045 Async reset: rst=0 asserted mid-cycle with dec_val=1 -> dec_val=0 immediately, without waiting for a clock edge.
